// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared opcodes, ALU codes, control bundles and FSM encoding for pipe_controller
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_ACC_BASE = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic {ACC_IDLE = 1'b0, ACC_BUSY = 1'b1} acc_state_t;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic       jal;
        logic       beq;
        logic       bne;
        logic [2:0] alucontrol;
    } dec_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       jal;
        logic [2:0] alucontrol;
        logic       alusrc;
        logic       regdst;
    } e_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
        logic jal;
    } m_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic jal;
    } w_ctrl_t;

    // Channel k lives at opcode 6'b111111 - k, so the top num_acc opcodes are reserved.
    function automatic logic is_acc_op(input logic [5:0] op, input int num_acc);
        logic [6:0] lim;
        lim = 7'd64 - 7'(num_acc);
        return {1'b0, op} >= lim;
    endfunction

endpackage

// File: rtl/pipe_controller_if.sv
// rtl/pipe_controller_if.sv - decode, pipeline-control and accelerator handshake bundle
interface pipe_controller_if #(parameter int NUM_ACC = 2) ();
    logic [5:0]         opD;
    logic [5:0]         functD;
    logic               equalD;
    logic               stallD;
    logic               flushE;
    logic [NUM_ACC-1:0] acc_done;
    logic               jumpD, jalD, branchD, pcsrcD, illegalD;
    logic               regwriteE, memtoregE, alusrcE, regdstE, jalE;
    logic [2:0]         alucontrolE;
    logic               regwriteM, memtoregM, memwriteM, jalM;
    logic               regwriteW, memtoregW, jalW;
    logic [NUM_ACC-1:0] acc_req;
    logic               accbypass;
    logic               acc_timeout;

    modport master (
        output opD, functD, equalD, stallD, flushE, acc_done,
        input  jumpD, jalD, branchD, pcsrcD, illegalD,
        input  regwriteE, memtoregE, alusrcE, regdstE, jalE, alucontrolE,
        input  regwriteM, memtoregM, memwriteM, jalM,
        input  regwriteW, memtoregW, jalW,
        input  acc_req, accbypass, acc_timeout
    );

    modport slave (
        input  opD, functD, equalD, stallD, flushE, acc_done,
        output jumpD, jalD, branchD, pcsrcD, illegalD,
        output regwriteE, memtoregE, alusrcE, regdstE, jalE, alucontrolE,
        output regwriteM, memtoregM, memwriteM, jalM,
        output regwriteW, memtoregW, jalW,
        output acc_req, accbypass, acc_timeout
    );
endinterface

// File: rtl/acc_offload_fsm.sv
// rtl/acc_offload_fsm.sv - multi-channel accelerator issue/wait FSM with timeout
module acc_offload_fsm
    import pipe_pkg::*;
#(
    parameter int NUM_ACC     = 2,
    parameter int ACC_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic               stall,
    input  logic [NUM_ACC-1:0] acc_done,
    output logic [NUM_ACC-1:0] acc_req,
    output logic               accbypass,
    output logic               acc_timeout
);
    localparam int CH_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    acc_state_t       state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       chan;
    logic             issue, done_hit, at_limit;

    always_comb begin
        chan        = OP_ACC_BASE - op;
        issue       = rst_n && (state_q == ACC_IDLE) && is_acc_op(op, NUM_ACC) && !stall;
        acc_req     = issue ? (NUM_ACC'(1) << chan) : '0;
        done_hit    = acc_done[ch_q];
        at_limit    = (cnt_q == CNT_W'(ACC_TIMEOUT - 1));
        // Completion beats timeout when both land in the same cycle.
        acc_timeout = (state_q == ACC_BUSY) && at_limit && !done_hit;
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        if (state_q == ACC_IDLE) begin
            if (issue) begin
                state_d = ACC_BUSY;
                ch_d    = chan[CH_W-1:0];
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (done_hit || at_limit) begin
                state_d = ACC_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
        end
    end

    assign accbypass = (state_q == ACC_BUSY);

endmodule

// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - MIPS decode, E/M/W control pipeline and accelerator offload
module pipe_controller
    import pipe_pkg::*;
#(
    parameter int NUM_ACC     = 2,
    parameter int ACC_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic             clk,
    input  logic             reset,
    pipe_controller_if.slave bus
);
    dec_ctrl_t dec;
    logic      illegal;
    e_ctrl_t   e_q, e_d;
    m_ctrl_t   m_q, m_d;
    w_ctrl_t   w_q, w_d;

    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        unique case (bus.opD)
            OP_RTYPE: begin
                dec.regwrite = 1'b1;
                dec.regdst   = 1'b1;
                unique case (bus.functD)
                    FN_ADD:  dec.alucontrol = ALU_ADD;
                    FN_SUB:  dec.alucontrol = ALU_SUB;
                    FN_AND:  dec.alucontrol = ALU_AND;
                    FN_OR:   dec.alucontrol = ALU_OR;
                    FN_SLT:  dec.alucontrol = ALU_SLT;
                    default: begin
                        dec.alucontrol = ALU_ADD;
                        illegal        = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.alucontrol = ALU_ADD; end
            OP_ANDI: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.alucontrol = ALU_AND; end
            OP_ORI:  begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.alucontrol = ALU_OR;  end
            OP_SLTI: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.alucontrol = ALU_SLT; end
            OP_LW: begin
                dec.regwrite   = 1'b1;
                dec.alusrc     = 1'b1;
                dec.memtoreg   = 1'b1;
                dec.alucontrol = ALU_ADD;
            end
            OP_SW:  begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; dec.alucontrol = ALU_ADD; end
            OP_BEQ: begin dec.beq = 1'b1; dec.alucontrol = ALU_SUB; end
            OP_BNE: begin dec.bne = 1'b1; dec.alucontrol = ALU_SUB; end
            OP_J:   dec.jump = 1'b1;
            OP_JAL: begin dec.jump = 1'b1; dec.jal = 1'b1; dec.regwrite = 1'b1; end
            default: illegal = !is_acc_op(bus.opD, NUM_ACC);
        endcase
    end

    assign bus.jumpD    = dec.jump;
    assign bus.jalD     = dec.jal;
    assign bus.branchD  = dec.beq | dec.bne;
    assign bus.pcsrcD   = (dec.beq & bus.equalD) | (dec.bne & ~bus.equalD);
    assign bus.illegalD = illegal;

    always_comb begin
        e_d = bus.flushE ? '0 : e_ctrl_t'{dec.regwrite, dec.memtoreg, dec.memwrite, dec.jal,
                                          dec.alucontrol, dec.alusrc, dec.regdst};
        m_d = m_ctrl_t'{e_q.regwrite, e_q.memtoreg, e_q.memwrite, e_q.jal};
        w_d = w_ctrl_t'{m_q.regwrite, m_q.memtoreg, m_q.jal};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign bus.regwriteE   = e_q.regwrite;
    assign bus.memtoregE   = e_q.memtoreg;
    assign bus.alusrcE     = e_q.alusrc;
    assign bus.regdstE     = e_q.regdst;
    assign bus.jalE        = e_q.jal;
    assign bus.alucontrolE = e_q.alucontrol;
    assign bus.regwriteM   = m_q.regwrite;
    assign bus.memtoregM   = m_q.memtoreg;
    assign bus.memwriteM   = m_q.memwrite;
    assign bus.jalM        = m_q.jal;
    assign bus.regwriteW   = w_q.regwrite;
    assign bus.memtoregW   = w_q.memtoreg;
    assign bus.jalW        = w_q.jal;

    acc_offload_fsm #(
        .NUM_ACC     (NUM_ACC),
        .ACC_TIMEOUT (ACC_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_acc (
        .clk         (clk),
        .rst_n       (reset),
        .op          (bus.opD),
        .stall       (bus.stallD),
        .acc_done    (bus.acc_done),
        .acc_req     (bus.acc_req),
        .accbypass   (bus.accbypass),
        .acc_timeout (bus.acc_timeout)
    );

endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
- Next-generation decode/control unit for the 5-stage MIPS pipeline.
- Decodes the D-stage opcode and funct, and carries control bits through E, M and W pipeline registers.
- Adds BNE, ANDI, ORI, SLTI and JAL, a defined illegal-opcode path, and a parametrised multi-channel accelerator offload FSM with a request/done handshake and a timeout counter.
- Sits beside the datapath; the hazard unit consumes accbypass to stall fetch and decode.

Parameters:
- NUM_ACC, 2, number of accelerator channels (1..4). Channel k is opcode 6'b111111 minus k.
- ACC_TIMEOUT, 64, maximum cycles in BUSY before the offload is abandoned (>=2).
- CNT_W, 7, timeout counter width. Must satisfy 2**CNT_W > ACC_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- opD  in  6  decode-stage opcode.
- functD  in  6  decode-stage funct field.
- equalD  in  1  branch comparator result.
- stallD  in  1  decode stall from the hazard unit; blocks accelerator issue.
- flushE  in  1  synchronous clear of the E-stage control register.
- acc_done  in  NUM_ACC  per-channel completion, 1-cycle pulse.
- jumpD, jalD, branchD, pcsrcD, illegalD  out  1  D-stage combinational controls.
- regwriteE, memtoregE, alusrcE, regdstE, jalE  out  1  E-stage controls.
- alucontrolE  out  3  ALU operation.
- regwriteM, memtoregM, memwriteM, jalM  out  1  M-stage controls.
- regwriteW, memtoregW, jalW  out  1  W-stage controls.
- acc_req  out  NUM_ACC  one-hot request, 1-cycle pulse.
- accbypass  out  1  high while an offload is in flight.
- acc_timeout  out  1  1-cycle pulse on abandoned offload.

Behaviour:
- Decode is combinational. Fields are regwrite, regdst, alusrc, memwrite, memtoreg, jump, jal, beq, bne, alucontrol.
  - R-type (000000): regwrite=1, regdst=1. alucontrol from funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct → alucontrol 010 and illegalD=1.
  - ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010: regwrite=1, alusrc=1. alucontrol is 010, 000, 001, 111 respectively.
  - LW 100011: regwrite=1, alusrc=1, memtoreg=1, alucontrol 010.
  - SW 101011: alusrc=1, memwrite=1, alucontrol 010.
  - BEQ 000100: beq=1, alucontrol 110.
  - BNE 000101: bne=1, alucontrol 110.
  - J 000010: jump=1.
  - JAL 000011: jump=1, jal=1, regwrite=1.
  - Accelerator opcodes: all controls 0, illegalD=0.
  - Any other opcode: all controls 0, illegalD=1. Decode never produces X.
- branchD = beq | bne. pcsrcD = (beq & equalD) | (bne & ~equalD).
- E register (regwrite, memtoreg, memwrite, jal, alucontrol, alusrc, regdst):
  - Async reset to 0.
  - flushE=1 loads 0 on the next edge.
- M and W registers: async reset to 0, load every cycle with no stall input. Pipeline latency D→E→M→W is one cycle per stage.
- Accelerator FSM states are IDLE and BUSY. The latched channel register ch is log2(NUM_ACC) bits, minimum 1. Counter cnt is CNT_W bits.
  - IDLE: if opD is a channel-k opcode and stallD=0, acc_req[k]=1 for exactly that cycle. Next edge: ch←k, cnt←0, state←BUSY.
  - BUSY: cnt increments each cycle.
    - acc_done[ch]=1 → IDLE.
    - Else if cnt==ACC_TIMEOUT-1 → IDLE, with acc_timeout=1 during that final BUSY cycle (combinational from state/cnt).
    - acc_done and timeout in the same cycle: done wins, no timeout pulse.
    - acc_done on channels other than ch is ignored.
    - An accelerator opcode presented while BUSY is not issued. The hazard unit holds it via accbypass, and it issues once back in IDLE.
  - accbypass = (state==BUSY), registered. It rises the cycle after acc_req and falls the cycle after done or timeout.
  - acc_req is combinational from IDLE plus decode; it is 0 whenever reset is asserted.
- Reset mid-offload: FSM returns to IDLE immediately. accbypass, acc_req and acc_timeout go to 0, cnt and ch go to 0. A later acc_done pulse is ignored.
- flushE does not affect the FSM.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ACC_BASE=6'b111111);
  - funct constants;
  - ALU codes (ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111);
  - the FSM state encoding.
- One sub-module, acc_offload_fsm, parametrised by NUM_ACC, ACC_TIMEOUT and CNT_W. Decode and the pipeline registers stay in pipe_controller.

Test Plan:
- Reset held low for 3 cycles with opD=000000 → all E/M/W outputs 0, accbypass=0. Release, R-type ADD → regwriteW=1 exactly 3 edges after decode, alucontrolE=010.
- BNE with equalD=0 → pcsrcD=1. BNE with equalD=1 → pcsrcD=0. BEQ with equalD=1 → pcsrcD=1. opD=111000 → illegalD=1 and no regwrite propagates.
- LW followed by flushE=1 on the capture edge → regwriteE=0 and memtoregE=0; next instruction flows normally.
- opD=111110 (channel 1), stallD=0 → acc_req=2'b10 for 1 cycle, accbypass=1 next cycle. acc_done=2'b01 ignored; acc_done=2'b10 after 5 cycles → accbypass=0 next cycle, no acc_timeout.
- Channel 0 issue with no done → acc_timeout pulses on BUSY cycle 64, accbypass drops next edge. Repeat with acc_done[0] in that same cycle → no acc_timeout.
- Reset asserted at BUSY cycle 10 → accbypass=0 asynchronously. A later acc_done pulse gives no state change. An issue with stallD=1 → acc_req stays 0.
